sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 16-bit SRAM. It accepts read or write requests from two independent requesters, selects one per access (round-robin by default), and drives the SRAM address, data and strobes through a fixed setup/access/done sequence. It acknowledges the owner with a single-cycle pulse. It sits between the datapath clients and the SRAM pins and replaces direct single-client write sequencing.

---
 rtl/sram_arb_pkg.sv | 8 +
 rtl/sram_arbiter_rr_arb2.sv | 23 ++
 rtl/sram_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, default widths and owner ids for the SRAM arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-way winner select; round-robin pointer, or fixed port-0 priority
// when SRAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_gnt_en,
  output logic o_winner
);
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign o_winner = (!i_req0 && i_req1) ? PORT1 : PORT0;
`else
  logic r_ptr;
  assign o_winner = (i_req0 && i_req1) ? r_ptr : (i_req1 ? PORT1 : PORT0);
  // pointer hands the next tie to the port that just lost
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= PORT0;
    else if (i_gnt_en) r_ptr <= ~o_winner;
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port SRAM arbiter and setup/access/done sequencer.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_q,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe
);
  state_t            r_state;
  logic              r_owner, r_we, r_ack0, r_ack1, r_gnt0, r_gnt1;
  logic              r_cs, r_swe, r_oe, r_doe;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_start, w_win, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_start = (r_state == IDLE) && (p0_req || p1_req);
  assign w_we    = w_win ? p1_we : p0_we;
  assign w_addr  = w_win ? p1_addr : p0_addr;
  assign w_wdata = w_win ? p1_wdata : p0_wdata;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_gnt_en (w_start),
    .o_winner (w_win)
  );

  // strobes are registered alongside the state so they are glitch-free at the pins
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_owner <= PORT0;
      r_we    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_cs    <= 1'b0;
      r_swe   <= 1'b0;
      r_oe    <= 1'b0;
      r_doe   <= 1'b0;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= SETUP;
          r_owner <= w_win;
          r_we    <= w_we;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_cs    <= 1'b1;
          r_oe    <= !w_we;
          r_doe   <= w_we;
          r_gnt0  <= (w_win == PORT0);
          r_gnt1  <= (w_win == PORT1);
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= 4'(ACCESS_CYCLES - 1);
          r_swe   <= r_we;
        end
        ACCESS: if (r_cnt == 4'd0) begin
          r_state <= DONE;
          r_swe   <= 1'b0;
          r_oe    <= 1'b0;
          r_ack0  <= (r_owner == PORT0);
          r_ack1  <= (r_owner == PORT1);
          if (!r_we) r_rdata <= sram_q;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_cs    <= 1'b0;
          r_doe   <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end

  assign p0_ack       = r_ack0;
  assign p1_ack       = r_ack1;
  assign p0_gnt       = r_gnt0;
  assign p1_gnt       = r_gnt1;
  assign rdata        = r_rdata;
  assign sram_address = r_addr;
  assign sram_data    = r_wdata;
  assign sram_data_oe = r_doe;
  assign sram_cs      = r_cs;
  assign sram_we      = r_swe;
  assign sram_oe      = r_oe;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table plus scoreboard bench for sram_arbiter (default and ACCESS_CYCLES=1).
module tb_sram_arbiter;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0, sram_q = '0;
  logic p0_ack, p1_ack, p0_gnt, p1_gnt, sram_data_oe, sram_cs, sram_we, sram_oe;
  logic [15:0] rdata, sram_address, sram_data;

  logic d1_req = 1'b0, d1_we = 1'b0;
  logic [15:0] d1_addr = '0;
  logic d1_ack0, d1_ack1, d1_gnt0, d1_gnt1, d1_doe, d1_cs, d1_swe, d1_oe;
  logic [15:0] d1_rdata, d1_saddr, d1_sdata;

  int total = 0, bad = 0, cyc = 0;
  logic [15:0] last_rd = '0;

  typedef struct packed {logic owner; logic we; logic [15:0] rdata;} exp_t;
  exp_t sb[$];
  exp_t e;
  int ack_cyc[$];

  typedef struct {logic port; logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] q;} vec_t;
  vec_t vt[6];

  sram_arbiter dut (
    .clk(clk), .reset(reset), .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .rdata(rdata),
    .sram_address(sram_address), .sram_data(sram_data), .sram_data_oe(sram_data_oe),
    .sram_q(sram_q), .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .p0_req(d1_req), .p1_req(1'b0), .p0_we(d1_we), .p1_we(1'b0),
    .p0_addr(d1_addr), .p1_addr(16'h0), .p0_wdata(16'h0), .p1_wdata(16'h0),
    .p0_ack(d1_ack0), .p1_ack(d1_ack1), .p0_gnt(d1_gnt0), .p1_gnt(d1_gnt1), .rdata(d1_rdata),
    .sram_address(d1_saddr), .sram_data(d1_sdata), .sram_data_oe(d1_doe),
    .sram_q(sram_q), .sram_cs(d1_cs), .sram_we(d1_swe), .sram_oe(d1_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rng(input int lo, input int hi);
    logic [7:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // scoreboard: each ack pops the oldest expected access
  always @(negedge clk) begin
    if (p0_gnt || p1_gnt) check("gnt_exclusive", 32'(p0_gnt & p1_gnt), 32'd0);
    if (p0_ack || p1_ack) begin
      ack_cyc.push_back(cyc);
      if (sb.size() == 0) check("unexpected_ack", 32'({p0_ack, p1_ack}), 32'd0);
      else begin
        e = sb.pop_front();
        check("ack_owner", 32'({p0_ack, p1_ack}), e.owner ? 32'd1 : 32'd2);
        if (!e.we) check("rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
  endtask

  task automatic do_access(input logic port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] q);
    logic [7:0] m_cs = '0, m_we = '0, m_oe = '0, m_doe = '0, m_gnt = '0, m_ngnt = '0, m_ack = '0;
    logic [15:0] a_addr = '0, a_data = '0;
    @(negedge clk);
    sb.push_back({port, we, q});
    if (!we) last_rd = q;
    sram_q = ~q;
    set_port(port, 1'b1, we, addr, wdata);
    for (int k = 0; k < 8; k++) begin
      m_cs[k]   = sram_cs;
      m_we[k]   = sram_we;
      m_oe[k]   = sram_oe;
      m_doe[k]  = sram_data_oe;
      m_gnt[k]  = port ? p1_gnt : p0_gnt;
      m_ngnt[k] = port ? p0_gnt : p1_gnt;
      m_ack[k]  = port ? p1_ack : p0_ack;
      if (k == 2) begin a_addr = sram_address; a_data = sram_data; end
      if (k == 1) set_port(port, 1'b1, ~we, ~addr, ~wdata);
      if (k == 7) check("addr_hold_idle", 32'(sram_address), 32'(addr));
      sram_q = (k == AC + 1) ? q : ~q;
      if (m_ack[k]) set_port(port, 1'b0, ~we, ~addr, ~wdata);
      @(negedge clk);
    end
    set_port(port, 1'b0, 1'b0, 16'h0, 16'h0);
    check("cs_window", 32'(m_cs), 32'(rng(1, AC + 2)));
    check("we_window", 32'(m_we), we ? 32'(rng(2, AC + 1)) : 32'd0);
    check("oe_window", 32'(m_oe), we ? 32'd0 : 32'(rng(1, AC + 1)));
    check("doe_window", 32'(m_doe), we ? 32'(rng(1, AC + 2)) : 32'd0);
    check("gnt_window", 32'(m_gnt), 32'(rng(1, AC + 2)));
    check("other_gnt", 32'(m_ngnt), 32'd0);
    check("ack_latency", 32'(m_ack), 32'(rng(AC + 2, AC + 2)));
    check("sram_address", 32'(a_addr), 32'(addr));
    if (we) check("sram_data", 32'(a_data), 32'(wdata));
    if (we) check("rdata_held", 32'(rdata), 32'(last_rd));
  endtask

  initial begin
    int d1_lat;
    logic [15:0] d1_rd, d1_ad;
    vt[0] = '{1'b0, 1'b1, 16'd100,  16'd10,   16'h0000};
    vt[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    vt[2] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h5A5A};
    vt[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
    vt[4] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
    vt[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001};

    #1 reset = 1'b1;
    #1;
    check("reset_strobes", 32'({p0_ack, p1_ack, p0_gnt, p1_gnt, sram_cs, sram_we, sram_oe, sram_data_oe}), 32'd0);
    check("reset_addr", 32'(sram_address), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].q);

    // reset in the middle of a port-0 write
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 16'h0123, 16'h4567);
    repeat (2) @(negedge clk);
    check("pre_reset_we", 32'(sram_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_strobes", 32'({p0_ack, p1_ack, p0_gnt, p1_gnt, sram_cs, sram_we, sram_oe, sram_data_oe}), 32'd0);
    check("async_reset_bus", 32'({sram_address, sram_data}), 32'd0);
    check("async_reset_rdata", 32'(rdata), 32'd0);
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", 32'({p0_gnt, p1_gnt, sram_cs}), 32'd0);
    do_access(1'b1, 1'b0, 16'h0777, 16'h0, 16'hC0DE);

    // both ports request continuously; pointer was reset so port 0 leads
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_cyc.delete();
    sram_q = 16'h1111;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      sb.push_back({1'b0, 1'b0, 16'h1111});
`else
      sb.push_back({i[0], 1'b0, 16'h1111});
`endif
    end
    set_port(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    for (int k = 0; k < 40 && ack_cyc.size() < 4; k++) begin
      @(negedge clk);
      #1;
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    check("contention_acks", 32'(ack_cyc.size()), 32'd4);
    for (int i = 1; i < ack_cyc.size() && i < 4; i++) check("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(AC + 3));
    repeat (8) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // ACCESS_CYCLES=1 instance, read at the top address
    @(negedge clk);
    sram_q = 16'h7777;
    d1_addr = 16'hFFFF;
    d1_we = 1'b0;
    d1_req = 1'b1;
    d1_lat = -1;
    d1_rd = '0;
    d1_ad = '0;
    for (int k = 0; k < 6; k++) begin
      if (d1_ack0 && d1_lat < 0) begin d1_lat = k; d1_rd = d1_rdata; d1_ad = d1_saddr; d1_req = 1'b0; end
      @(negedge clk);
    end
    d1_req = 1'b0;
    check("d1_latency", 32'(d1_lat), 32'd3);
    check("d1_rdata", 32'(d1_rd), 32'h7777);
    check("d1_address", 32'(d1_ad), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
